conv_encoder_packer: RTL
========================

CONV_ENCODER_PACKER -- requirements
Module: conv_encoder_packer

Interface
REQ-001 Parameter K, default 5, is the constraint length; the only legal values are 3, 5 and 7.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_data  input  8  data byte; bit 0 is encoded first.
REQ-005 in_valid  input  1  in_data, in_last and tail_en are offered.
REQ-006 in_last  input  1  the offered byte is the last of the frame.
REQ-007 tail_en  input  1  append K-1 zero tail bits after the last byte; sampled with in_last.
REQ-008 in_ready  output  1  the block can accept a byte this cycle.
REQ-009 out_data  output  8  packed symbols {s3,s2,s1,s0}; s0 sits in bits [1:0].
REQ-010 out_valid  output  1  out_data holds a symbol byte.
REQ-011 out_ready  input  1  the consumer accepts out_data.
REQ-012 out_last  output  1  out_data is the final byte of the frame.
REQ-013 busy  output  1  a frame is in progress, i.e. the block is not IDLE.

Function
REQ-014 Polynomials (octal) SHALL be: K=3 G0=7, G1=5; K=5 G0=23, G1=35; K=7 G0=171, G1=133.
REQ-015 Register r SHALL be {state[K-2:0], bit}, with r[0] the newest bit.
REQ-016 Each symbol SHALL be {^(r&G0), ^(r&G1)}; afterwards state SHALL become {state[K-3:0], bit}.
REQ-017 FSM states SHALL be IDLE, ENC, TAIL and FLUSH.
REQ-018 in_ready SHALL be 1 only in IDLE with no pending full output byte.
REQ-019 A byte SHALL be accepted when in_valid and in_ready are both 1.
REQ-020 ENC SHALL encode one bit per cycle, bit 0 through bit 7.
REQ-021 After bit 7 of a non-last byte, the FSM SHALL return to IDLE.
REQ-022 After bit 7 of the last byte, the FSM SHALL go to TAIL if tail_en=1, otherwise to FLUSH.
REQ-023 TAIL SHALL encode exactly K-1 zero bits, one per cycle, then go to FLUSH.
REQ-024 A 2-bit symbol counter SHALL place symbols s0..s3; when the 4th symbol is written, out_valid SHALL assert the next cycle.
REQ-025 Encoding SHALL stall, with state unchanged, while a completed byte is waiting on out_ready=0.
REQ-026 In FLUSH, a partial byte SHALL be padded with 00 symbols in its upper positions and emitted with out_last=1.
REQ-027 If the symbol count is a multiple of 4, the last full byte SHALL carry out_last=1 instead of a padded byte.
REQ-028 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 The handshake of the out_last byte SHALL clear state and the counter to 0 and return the FSM to IDLE.
REQ-030 in_valid offered while in_ready=0 SHALL be ignored, with no side effects.
REQ-031 With out_ready held at 1, an 8-bit frame without tail SHALL produce 2 output bytes within 11 cycles of acceptance.

Reset
REQ-032 When rst=1 on a clock edge, the FSM SHALL go to IDLE and state and the symbol counter SHALL clear to 0.
REQ-033 During and after reset, out_valid, out_last and busy SHALL be 0 and out_data SHALL be 8'h00.
REQ-034 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-035 Reset mid-frame SHALL discard all partial symbols, and no output byte SHALL appear afterwards.

Structure
REQ-036 Shared package viterbi_pkg SHALL hold the per-K G0/G1 constants, the symbol width (2) and the FSM state enum.
REQ-037 One sub-module, conv_enc_core, SHALL hold the shift register and parity logic; the packer and FSM SHALL stay in the top module.

Verification
REQ-038 K=5, 0x00, in_last=1, tail_en=0 -> output bytes 0x00, 0x00; out_last=1 on the second.
REQ-039 K=5, 0xFF, in_last=1, tail_en=0 -> output bytes 0x47, 0xAA; out_last=1 on 0xAA.
REQ-040 K=3, 0x01, in_last=1, tail_en=1 -> output bytes 0x3B, 0x00, 0x00; out_last=1 on the third.
REQ-041 K=5, 0xFF with out_ready=0 for 20 cycles -> 0x47 held stable, in_ready=0, then 0x47, 0xAA delivered with no loss.
REQ-042 rst pulsed during ENC -> out_valid=0, busy=0, next frame 0xFF yields 0x47, 0xAA.
REQ-043 All K, random 2-4 byte frames with tail -> the viterbi decoder recovers every bit with 0 errors.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants for the rate-1/2 convolutional encoder family:
// generator polynomials per constraint length, symbol width and FSM states.
package viterbi_pkg;

  localparam int SYM_W = 2;

  localparam logic [6:0] G0_K3 = 7'o7;
  localparam logic [6:0] G1_K3 = 7'o5;
  localparam logic [6:0] G0_K5 = 7'o23;
  localparam logic [6:0] G1_K5 = 7'o35;
  localparam logic [6:0] G0_K7 = 7'o171;
  localparam logic [6:0] G1_K7 = 7'o133;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    TAIL  = 2'd2,
    FLUSH = 2'd3
  } fsm_t;

  function automatic logic [6:0] poly_g0(input int k);
    case (k)
      3:       return G0_K3;
      7:       return G0_K7;
      default: return G0_K5;
    endcase
  endfunction

  function automatic logic [6:0] poly_g1(input int k);
    case (k)
      3:       return G1_K3;
      7:       return G1_K7;
      default: return G1_K5;
    endcase
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Shift register and parity taps of the convolutional encoder: one input bit
// in, one 2-bit symbol {G0 parity, G1 parity} out, combinationally.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter int K = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SYM_W-1:0] sym
);

  localparam logic [6:0]   G0_ALL = poly_g0(K);
  localparam logic [6:0]   G1_ALL = poly_g1(K);
  localparam logic [K-1:0] G0     = G0_ALL[K-1:0];
  localparam logic [K-1:0] G1     = G1_ALL[K-1:0];

  logic [K-2:0] state;
  logic [K-1:0] r;

  // Newest bit sits in r[0]; the low K-1 bits of r are the next state.
  assign r   = {state, din};
  assign sym = {^(r & G0), ^(r & G1)};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= '0;
    end else if (en) begin
      state <= r[K-2:0];
    end
  end

endmodule

// File: rtl/conv_encoder_packer.sv
// Byte-in convolutional encoder that packs four 2-bit symbols per output byte,
// optionally appends a zero tail, and flushes a padded final byte.
module conv_encoder_packer
  import viterbi_pkg::*;
#(
  parameter int K = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       tail_en,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam logic [2:0] TAIL_END = 3'(K - 2);

  function automatic logic [7:0] pad_byte(input logic [5:0] sbuf, input logic [1:0] cnt);
    case (cnt)
      2'd1:    pad_byte = {6'd0, sbuf[1:0]};
      2'd2:    pad_byte = {4'd0, sbuf[3:0]};
      2'd3:    pad_byte = {2'd0, sbuf};
      default: pad_byte = 8'd0;
    endcase
  endfunction

  fsm_t             fsm, fsm_nxt;
  logic [7:0]       in_byte;
  logic             last_q, tail_q;
  logic [2:0]       bit_idx, tail_idx;
  logic [5:0]       sym_buf;
  logic [1:0]       sym_cnt;
  logic [SYM_W-1:0] sym;
  logic             stall, advance, accept, enc_bit;
  logic             final_sym, full_load, pad_load, last_hs;

  assign stall     = out_valid && !out_ready;
  assign advance   = ((fsm == ENC) || (fsm == TAIL)) && !stall;
  assign in_ready  = (fsm == IDLE) && !out_valid;
  assign accept    = in_valid && in_ready;
  assign busy      = (fsm != IDLE);
  assign enc_bit   = (fsm == ENC) ? in_byte[bit_idx] : 1'b0;
  assign last_hs   = out_valid && out_ready && out_last;
  assign full_load = advance && (sym_cnt == 2'd3);

  // A symbol that completes the frame exactly on a byte boundary tags that byte as last.
  assign final_sym = ((fsm == ENC) && (bit_idx == 3'd7) && last_q && !tail_q) ||
                     ((fsm == TAIL) && (tail_idx == TAIL_END));

  // The padded byte is loaded once, as soon as the output register is free.
  assign pad_load = (fsm == FLUSH) && (sym_cnt != 2'd0) && !(out_valid && out_last) &&
                    (!out_valid || out_ready);

  conv_enc_core #(.K(K)) u_core (
    .clk (clk),
    .rst (rst),
    .clr (last_hs),
    .en  (advance),
    .din (enc_bit),
    .sym (sym)
  );

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:  if (accept) fsm_nxt = ENC;
      ENC: begin
        if (advance && (bit_idx == 3'd7)) begin
          if (!last_q)     fsm_nxt = IDLE;
          else if (tail_q) fsm_nxt = TAIL;
          else             fsm_nxt = FLUSH;
        end
      end
      TAIL:  if (advance && (tail_idx == TAIL_END)) fsm_nxt = FLUSH;
      FLUSH: if (last_hs) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      bit_idx   <= 3'd0;
      tail_idx  <= 3'd0;
      sym_cnt   <= 2'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      fsm <= fsm_nxt;
      if (accept) begin
        bit_idx  <= 3'd0;
        tail_idx <= 3'd0;
      end else if (advance && (fsm == ENC)) begin
        bit_idx <= bit_idx + 3'd1;
      end else if (advance && (fsm == TAIL)) begin
        tail_idx <= tail_idx + 3'd1;
      end
      if (last_hs)      sym_cnt <= 2'd0;
      else if (advance) sym_cnt <= sym_cnt + 2'd1;
      if (full_load) begin
        out_data  <= {sym, sym_buf};
        out_valid <= 1'b1;
        out_last  <= final_sym;
      end else if (pad_load) begin
        out_data  <= pad_byte(sym_buf, sym_cnt);
        out_valid <= 1'b1;
        out_last  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Frame capture and partial-byte symbol storage; stale contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      in_byte <= in_data;
      last_q  <= in_last;
      tail_q  <= in_last && tail_en;
    end
    if (advance) begin
      case (sym_cnt)
        2'd0:    sym_buf[1:0] <= sym;
        2'd1:    sym_buf[3:2] <= sym;
        2'd2:    sym_buf[5:4] <= sym;
        default: ;
      endcase
    end
  end

endmodule
